// File: rtl/filter_dispatcher.sv
// filter_dispatcher: round-robin issue of upstream particle-pair beats into
// the filter input buffers, skipping backpressured filters, with a drain
// period before signalling end-of-cell.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; rr_ptr is kept across cells
// S_RUN   | accepting beats, one per cycle while any filter is free
// S_DRAIN | last beat issued; counting DRAIN_CYCLES before done
module filter_dispatcher #(
    parameter int NUM_FILTER   = 8,
    parameter int DATA_WIDTH   = 128,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic [NUM_FILTER-1:0] Filter_Backpressure,
    output logic [NUM_FILTER-1:0] filter_valid,
    output logic [DATA_WIDTH-1:0] filter_data,
    output logic                  dispatch_done,
    output logic [15:0]           dispatch_count,
    output logic                  busy
);

    localparam int PTR_W = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(NUM_FILTER - 1);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [NUM_FILTER-1:0] ONE  = NUM_FILTER'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] target;
    logic [PTR_W-1:0] ptr_after;
    logic [CNT_W-1:0] drain_cnt;
    logic             any_free;
    logic             accept;
    logic             drain_last;

    // Rotating priority search starting at rr_ptr; first non-backpressured filter wins.
    always_comb begin
        int idx;
        logic found;
        target = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_FILTER; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_FILTER;
            if (!found && !Filter_Backpressure[idx]) begin
                found  = 1'b1;
                target = PTR_W'(idx);
            end
        end
    end

    assign any_free      = ~&Filter_Backpressure;
    assign in_ready      = (state == S_RUN) && any_free;
    assign accept        = in_valid && in_ready;
    assign ptr_after     = (target == PTR_MAX) ? '0 : target + PTR_W'(1);
    assign drain_last    = (state == S_DRAIN) && (drain_cnt == DRAIN_END);
    assign dispatch_done = drain_last;
    assign busy          = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start outside IDLE is ignored.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)             state_next = S_RUN;
            S_RUN:   if (accept && in_last) state_next = S_DRAIN;
            S_DRAIN: if (drain_last)        state_next = S_IDLE;
            default:                        state_next = S_IDLE;
        endcase
    end

    // Issue datapath: registered one-hot strobe, broadcast data, pointer and beat count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr         <= '0;
            filter_valid   <= '0;
            filter_data    <= '0;
            dispatch_count <= '0;
        end else begin
            filter_valid <= '0;
            if (state == S_IDLE && start) begin
                dispatch_count <= '0;
            end
            if (accept) begin
                filter_valid <= ONE << target;
                filter_data  <= in_data;
                rr_ptr       <= ptr_after;
                if (dispatch_count != 16'hFFFF) begin
                    dispatch_count <= dispatch_count + 16'd1;
                end
            end
        end
    end

    // Drain timer: counts up from zero for as long as the FSM sits in DRAIN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (state == S_DRAIN && !drain_last) begin
            drain_cnt <= drain_cnt + CNT_W'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_filter_dispatcher.sv
// Scoreboard bench for filter_dispatcher (4 filters, drain of 4 cycles).
module tb_filter_dispatcher;

    localparam int NF = 4;
    localparam int DW = 32;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic [NF-1:0] bp;
    logic [NF-1:0] filter_valid;
    logic [DW-1:0] filter_data;
    logic          dispatch_done;
    logic [15:0]   dispatch_count;
    logic          busy;

    int errors = 0;
    int checks = 0;
    logic [NF+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    filter_dispatcher #(
        .NUM_FILTER  (NF),
        .DATA_WIDTH  (DW),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_last            (in_last),
        .in_ready           (in_ready),
        .Filter_Backpressure(bp),
        .filter_valid       (filter_valid),
        .filter_data        (filter_data),
        .dispatch_done      (dispatch_done),
        .dispatch_count     (dispatch_count),
        .busy               (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one beat expected to be accepted and routed to exp_oh.
    task automatic beat(input logic [DW-1:0] d, input logic [NF-1:0] bp_v,
                        input logic last, input logic [NF-1:0] exp_oh);
        in_valid = 1'b1;
        in_data  = d;
        bp       = bp_v;
        in_last  = last;
        @(negedge clk);
        chk("beat_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back({exp_oh, d});
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected beat.
    initial begin
        logic [NF+DW-1:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (filter_valid !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(filter_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_valid", 32'(filter_valid), 32'(e[NF+DW-1:DW]));
                    chk("strobe_data", filter_data, e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hdead;
        in_last  = 1'b1;
        bp       = '0;

        // reset held with start and in_valid asserted
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_fvalid", 32'(filter_valid), 32'd0);
            chk("rst_count", 32'(dispatch_count), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(dispatch_done), 32'd0);
            chk("rst_fdata", filter_data, 32'd0);
        end
        tick;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);
        tick;

        // rotation without backpressure
        start = 1'b1; tick; start = 1'b0;
        @(negedge clk);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_count", 32'(dispatch_count), 32'd0);
        chk("run_in_ready", 32'(in_ready), 32'd1);
        tick;
        beat(32'h100, 4'b0000, 1'b0, 4'b0001);
        beat(32'h101, 4'b0000, 1'b0, 4'b0010);
        beat(32'h102, 4'b0000, 1'b0, 4'b0100);
        beat(32'h103, 4'b0000, 1'b0, 4'b1000);
        beat(32'h104, 4'b0000, 1'b0, 4'b0001);
        beat(32'h105, 4'b0000, 1'b0, 4'b0010);
        @(negedge clk);
        chk("rot_count", 32'(dispatch_count), 32'd6);
        tick;
        @(negedge clk);
        chk("fdata_hold", filter_data, 32'h105);
        tick;

        // walk pointer to 1, then skip backpressured filters
        beat(32'h200, 4'b0000, 1'b0, 4'b0100);
        beat(32'h201, 4'b0000, 1'b0, 4'b1000);
        beat(32'h202, 4'b0000, 1'b0, 4'b0001);
        beat(32'h210, 4'b0010, 1'b0, 4'b0100);
        beat(32'h211, 4'b1000, 1'b0, 4'b0001);
        @(negedge clk);
        chk("skip_count", 32'(dispatch_count), 32'd11);
        tick;

        // all filters full
        in_valid = 1'b1; in_data = 32'h300; bp = 4'b1111;
        repeat (5) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_count", 32'(dispatch_count), 32'd11);
            tick;
        end
        beat(32'h301, 4'b1011, 1'b0, 4'b0100);
        bp = '0;

        // end of cell: last accept at N, now in N+1
        beat(32'h400, 4'b0000, 1'b0, 4'b1000);
        beat(32'h401, 4'b0000, 1'b0, 4'b0001);
        beat(32'h402, 4'b0000, 1'b1, 4'b0010);
        in_valid = 1'b1; in_data = 32'h4ff; in_last = 1'b1;
        @(negedge clk);
        chk("eoc_n1_in_ready", 32'(in_ready), 32'd0);
        chk("eoc_n1_done", 32'(dispatch_done), 32'd0);
        chk("eoc_n1_busy", 32'(busy), 32'd1);
        tick; start = 1'b1;
        @(negedge clk);
        chk("eoc_n2_done", 32'(dispatch_done), 32'd0);
        chk("eoc_n2_in_ready", 32'(in_ready), 32'd0);
        tick; start = 1'b0;
        @(negedge clk);
        chk("eoc_n3_done", 32'(dispatch_done), 32'd0);
        tick;
        @(negedge clk);
        chk("eoc_n4_done", 32'(dispatch_done), 32'd1);
        chk("eoc_n4_busy", 32'(busy), 32'd1);
        tick;
        @(negedge clk);
        chk("eoc_n5_done", 32'(dispatch_done), 32'd0);
        chk("eoc_n5_busy", 32'(busy), 32'd0);
        chk("eoc_n5_in_ready", 32'(in_ready), 32'd0);
        chk("eoc_count", 32'(dispatch_count), 32'd15);
        tick;
        in_valid = 1'b0; in_last = 1'b0;

        // new cell continues rotation from saved pointer (2)
        start = 1'b1; tick; start = 1'b0;
        @(negedge clk);
        chk("restart_count", 32'(dispatch_count), 32'd0);
        tick;
        beat(32'h500, 4'b0000, 1'b0, 4'b0100);
        beat(32'h501, 4'b1000, 1'b0, 4'b0001);
        bp = '0;

        // reset mid-RUN for one cycle
        rst = 1'b0; tick; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_fvalid", 32'(filter_valid), 32'd0);
        chk("mid_rst_count", 32'(dispatch_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(dispatch_done), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick;
        start = 1'b1; tick; start = 1'b0;
        beat(32'h600, 4'b0000, 1'b0, 4'b0001);
        tick;
        tick;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
